// File: rtl/afe_ro_buf_reader.sv
// afe_ro_buf_reader: read-side master for the AFE readout sample SRAM.
// Drains a circular buffer region into a valid/ready stream via a 2-entry FIFO.
module afe_ro_buf_reader #(
   parameter int AFE_DATA_WIDTH = 32,
   parameter int ADDR_WIDTH     = 10
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   input  logic                      abort_i,
   input  logic [ADDR_WIDTH-1:0]     cfg_base_i,
   input  logic [ADDR_WIDTH:0]       cfg_size_i,
   input  logic [ADDR_WIDTH-1:0]     cfg_addr_i,
   input  logic [ADDR_WIDTH:0]       cfg_len_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      err_o,
   output logic [ADDR_WIDTH-1:0]     rd_ptr_o,
   output logic                      sram_cen_o,
   output logic                      sram_wen_o,
   output logic [ADDR_WIDTH-1:0]     sram_addr_o,
   input  logic [AFE_DATA_WIDTH-1:0] sram_data_i,
   output logic [AFE_DATA_WIDTH-1:0] data_o,
   output logic                      valid_o,
   input  logic                      ready_i
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   localparam logic [ADDR_WIDTH:0]   LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH+1:0] END_ONE = {{(ADDR_WIDTH+1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH+1:0] END_MAX = {2'b00, {ADDR_WIDTH{1'b1}}};

   state_t                    state;
   logic                      busy;
   logic                      done;
   logic                      err;
   logic [ADDR_WIDTH-1:0]     rd_ptr;
   logic [ADDR_WIDTH-1:0]     base;
   logic [ADDR_WIDTH-1:0]     last;
   logic [ADDR_WIDTH:0]       remaining;

   logic                      inflight;
   logic [1:0]                count;
   logic [AFE_DATA_WIDTH-1:0] head;
   logic [AFE_DATA_WIDTH-1:0] tail;

   logic [ADDR_WIDTH+1:0]     cfg_end;
   logic                      cfg_bad;
   logic                      pop;
   logic                      push;
   logic [1:0]                occ;
   logic                      credit;
   logic                      issue;
   logic                      kill;
   logic                      fin;
   logic [ADDR_WIDTH-1:0]     ptr_next;

   // Config check, credit-gated read issue and circular pointer advance
   always_comb begin
      cfg_end  = {2'b00, cfg_base_i} + {1'b0, cfg_size_i} - END_ONE;
      cfg_bad  = (cfg_size_i == '0)
               || (cfg_end > END_MAX)
               || (cfg_addr_i < cfg_base_i)
               || ({2'b00, cfg_addr_i} > cfg_end);
      pop      = (count != 2'd0) && ready_i;
      push     = inflight;
      occ      = count + {1'b0, inflight};
      credit   = (occ < 2'd2) || (pop && (occ == 2'd2));
      kill     = abort_i && busy;
      issue    = (state == RUN) && (remaining != '0) && credit
               && !abort_i && !rst_i;
      fin      = (state == DRAIN) && pop && (count == 2'd1) && !inflight;
      ptr_next = (rd_ptr == last) ? base : rd_ptr + PTR_ONE;
   end

   // Transfer control FSM with registered status outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         rd_ptr    <= '0;
         base      <= '0;
         last      <= '0;
         remaining <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (kill) begin
            state <= IDLE;
            busy  <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (start_i) begin
                     if (cfg_bad) begin
                        err <= 1'b1;
                     end else if (cfg_len_i == '0) begin
                        done <= 1'b1;
                     end else begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        rd_ptr    <= cfg_addr_i;
                        remaining <= cfg_len_i;
                        base      <= cfg_base_i;
                        last      <= cfg_end[ADDR_WIDTH-1:0];
                     end
                  end
               end
               RUN: begin
                  if (issue) begin
                     rd_ptr    <= ptr_next;
                     remaining <= remaining - LEN_ONE;
                     if (remaining == LEN_ONE) state <= DRAIN;
                  end
               end
               DRAIN: begin
                  if (fin) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Read-latency capture and 2-entry output FIFO with registered head
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         inflight <= 1'b0;
         count    <= 2'd0;
         head     <= '0;
         tail     <= '0;
      end else if (kill) begin
         inflight <= 1'b0;
         count    <= 2'd0;
      end else begin
         inflight <= issue;
         unique case ({push, pop})
            2'b11: begin
               if (count == 2'd1) begin
                  head <= sram_data_i;
               end else begin
                  head <= tail;
                  tail <= sram_data_i;
               end
            end
            2'b10: begin
               if (count == 2'd0) head <= sram_data_i;
               else tail <= sram_data_i;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= tail;
               count <= count - 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign busy_o      = busy;
   assign done_o      = done;
   assign err_o       = err;
   assign rd_ptr_o    = rd_ptr;
   assign sram_cen_o  = ~issue;
   assign sram_wen_o  = 1'b1;
   assign sram_addr_o = rd_ptr;
   assign data_o      = head;
   assign valid_o     = (count != 2'd0);

endmodule

// File: tb/tb_afe_ro_buf_reader.sv
// tb_afe_ro_buf_reader: directed vector tables plus hand sequences
// for afe_ro_buf_reader, with a 1-cycle-latency SRAM model.
module tb_afe_ro_buf_reader;

   logic        clk;
   logic        rst_i;
   logic        start_i;
   logic        abort_i;
   logic [9:0]  cfg_base_i;
   logic [10:0] cfg_size_i;
   logic [9:0]  cfg_addr_i;
   logic [10:0] cfg_len_i;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic [9:0]  rd_ptr_o;
   logic        sram_cen_o;
   logic        sram_wen_o;
   logic [9:0]  sram_addr_o;
   logic [31:0] sram_data_i;
   logic [31:0] data_o;
   logic        valid_o;
   logic        ready_i;

   int n_cmp = 0;
   int n_err = 0;

   logic [9:0]  m_base;
   logic [10:0] m_size;
   logic [9:0]  m_addr;
   logic [10:0] m_len;

   typedef struct {
      bit         st;
      bit         ab;
      bit         alt;
      bit         rdy;
      bit         cen;
      logic [9:0] a;
      bit         vld;
      logic [9:0] da;
      bit         dn;
      bit         bsy;
   } vec_t;

   vec_t q[$];

   afe_ro_buf_reader #(
      .AFE_DATA_WIDTH(32),
      .ADDR_WIDTH(10)
   ) dut (
      .clk_i(clk),
      .rst_i(rst_i),
      .start_i(start_i),
      .abort_i(abort_i),
      .cfg_base_i(cfg_base_i),
      .cfg_size_i(cfg_size_i),
      .cfg_addr_i(cfg_addr_i),
      .cfg_len_i(cfg_len_i),
      .busy_o(busy_o),
      .done_o(done_o),
      .err_o(err_o),
      .rd_ptr_o(rd_ptr_o),
      .sram_cen_o(sram_cen_o),
      .sram_wen_o(sram_wen_o),
      .sram_addr_o(sram_addr_o),
      .sram_data_i(sram_data_i),
      .data_o(data_o),
      .valid_o(valid_o),
      .ready_i(ready_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_f(logic [9:0] a);
      return 32'hCAFE_0000 + {22'd0, a} * 32'd3;
   endfunction

   initial sram_data_i = '0;
   always @(posedge clk) begin
      if (!sram_cen_o) sram_data_i <= mem_f(sram_addr_o);
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(logic [9:0] b, logic [10:0] s,
                          logic [9:0] a, logic [10:0] l);
      m_base = b; m_size = s; m_addr = a; m_len = l;
      cfg_base_i = b; cfg_size_i = s; cfg_addr_i = a; cfg_len_i = l;
   endtask

   task automatic add(bit st, bit ab, bit alt, bit rdy, bit cen,
                      logic [9:0] a, bit vld, logic [9:0] da,
                      bit dn, bit bsy);
      vec_t v;
      v.st = st; v.ab = ab; v.alt = alt; v.rdy = rdy; v.cen = cen;
      v.a = a; v.vld = vld; v.da = da; v.dn = dn; v.bsy = bsy;
      q.push_back(v);
   endtask

   // Entered and left at posedge+1; one vector per clock cycle.
   task automatic run_vecs(string tag);
      foreach (q[i]) begin
         start_i = q[i].st;
         abort_i = q[i].ab;
         ready_i = q[i].rdy;
         if (q[i].alt) begin
            cfg_base_i = 10'h300; cfg_size_i = 11'd0;
            cfg_addr_i = 10'h3FF; cfg_len_i = 11'd1;
         end else begin
            cfg_base_i = m_base; cfg_size_i = m_size;
            cfg_addr_i = m_addr; cfg_len_i = m_len;
         end
         @(negedge clk);
         chk($sformatf("%s c%0d cen", tag, i), 32'(sram_cen_o), 32'(q[i].cen));
         chk($sformatf("%s c%0d wen", tag, i), 32'(sram_wen_o), 32'd1);
         chk($sformatf("%s c%0d valid", tag, i), 32'(valid_o), 32'(q[i].vld));
         chk($sformatf("%s c%0d done", tag, i), 32'(done_o), 32'(q[i].dn));
         chk($sformatf("%s c%0d busy", tag, i), 32'(busy_o), 32'(q[i].bsy));
         chk($sformatf("%s c%0d err", tag, i), 32'(err_o), 32'd0);
         if (!q[i].cen)
            chk($sformatf("%s c%0d addr", tag, i), 32'(sram_addr_o), 32'(q[i].a));
         if (q[i].vld)
            chk($sformatf("%s c%0d data", tag, i), data_o, mem_f(q[i].da));
         tick();
      end
      start_i = 1'b0;
      abort_i = 1'b0;
      ready_i = 1'b1;
      cfg_base_i = m_base; cfg_size_i = m_size;
      cfg_addr_i = m_addr; cfg_len_i = m_len;
      q.delete();
   endtask

   task automatic fill_basic(bit busy_start);
      add(1, 0, 0, 1, 1, 10'h000, 0, 10'h000, 0, 0);
      add(0, 0, 0, 1, 0, 10'h010, 0, 10'h000, 0, 1);
      add(busy_start, 0, busy_start, 1, 0, 10'h011, 0, 10'h000, 0, 1);
      add(0, 0, 0, 1, 0, 10'h012, 1, 10'h010, 0, 1);
      add(0, 0, 0, 1, 0, 10'h013, 1, 10'h011, 0, 1);
      add(0, 0, 0, 1, 1, 10'h000, 1, 10'h012, 0, 1);
      add(0, 0, 0, 1, 1, 10'h000, 1, 10'h013, 0, 1);
      add(0, 0, 0, 1, 1, 10'h000, 0, 10'h000, 1, 0);
      add(0, 0, 0, 1, 1, 10'h000, 0, 10'h000, 0, 0);
   endtask

   task automatic reject(string nm, logic [9:0] b, logic [10:0] s,
                         logic [9:0] a, logic [10:0] l);
      set_cfg(b, s, a, l);
      start_i = 1'b1;
      @(negedge clk);
      chk({nm, " c0 cen"}, 32'(sram_cen_o), 32'd1);
      tick();
      start_i = 1'b0;
      @(negedge clk);
      chk({nm, " c1 err"}, 32'(err_o), 32'd1);
      chk({nm, " c1 busy"}, 32'(busy_o), 32'd0);
      chk({nm, " c1 cen"}, 32'(sram_cen_o), 32'd1);
      tick();
      @(negedge clk);
      chk({nm, " c2 err"}, 32'(err_o), 32'd0);
      chk({nm, " c2 busy"}, 32'(busy_o), 32'd0);
      tick();
   endtask

   initial begin
      rst_i = 1'b1;
      start_i = 1'b0;
      abort_i = 1'b0;
      ready_i = 1'b1;
      set_cfg(10'h000, 11'h400, 10'h010, 11'd4);
      tick();
      tick();
      @(negedge clk);
      chk("rst busy", 32'(busy_o), 32'd0);
      chk("rst done", 32'(done_o), 32'd0);
      chk("rst err", 32'(err_o), 32'd0);
      chk("rst valid", 32'(valid_o), 32'd0);
      chk("rst data", data_o, 32'd0);
      chk("rst cen", 32'(sram_cen_o), 32'd1);
      chk("rst wen", 32'(sram_wen_o), 32'd1);
      chk("rst addr", 32'(sram_addr_o), 32'd0);
      chk("rst rd_ptr", 32'(rd_ptr_o), 32'd0);
      tick();
      rst_i = 1'b0;

      // Basic in-order drain
      set_cfg(10'h000, 11'h400, 10'h010, 11'd4);
      fill_basic(1'b0);
      run_vecs("basic");
      chk("basic rd_ptr", 32'(rd_ptr_o), 32'h014);

      // Circular wrap
      set_cfg(10'h100, 11'd8, 10'h106, 11'd5);
      add(1, 0, 0, 1, 1, 10'h000, 0, 10'h000, 0, 0);
      add(0, 0, 0, 1, 0, 10'h106, 0, 10'h000, 0, 1);
      add(0, 0, 0, 1, 0, 10'h107, 0, 10'h000, 0, 1);
      add(0, 0, 0, 1, 0, 10'h100, 1, 10'h106, 0, 1);
      add(0, 0, 0, 1, 0, 10'h101, 1, 10'h107, 0, 1);
      add(0, 0, 0, 1, 0, 10'h102, 1, 10'h100, 0, 1);
      add(0, 0, 0, 1, 1, 10'h000, 1, 10'h101, 0, 1);
      add(0, 0, 0, 1, 1, 10'h000, 1, 10'h102, 0, 1);
      add(0, 0, 0, 1, 1, 10'h000, 0, 10'h000, 1, 0);
      run_vecs("wrap");
      chk("wrap rd_ptr", 32'(rd_ptr_o), 32'h103);

      // Backpressure: ready low in cycles 4..7
      set_cfg(10'h000, 11'h400, 10'h020, 11'd6);
      add(1, 0, 0, 1, 1, 10'h000, 0, 10'h000, 0, 0);
      add(0, 0, 0, 1, 0, 10'h020, 0, 10'h000, 0, 1);
      add(0, 0, 0, 1, 0, 10'h021, 0, 10'h000, 0, 1);
      add(0, 0, 0, 1, 0, 10'h022, 1, 10'h020, 0, 1);
      add(0, 0, 0, 0, 1, 10'h000, 1, 10'h021, 0, 1);
      add(0, 0, 0, 0, 1, 10'h000, 1, 10'h021, 0, 1);
      add(0, 0, 0, 0, 1, 10'h000, 1, 10'h021, 0, 1);
      add(0, 0, 0, 0, 1, 10'h000, 1, 10'h021, 0, 1);
      add(0, 0, 0, 1, 0, 10'h023, 1, 10'h021, 0, 1);
      add(0, 0, 0, 1, 0, 10'h024, 1, 10'h022, 0, 1);
      add(0, 0, 0, 1, 0, 10'h025, 1, 10'h023, 0, 1);
      add(0, 0, 0, 1, 1, 10'h000, 1, 10'h024, 0, 1);
      add(0, 0, 0, 1, 1, 10'h000, 1, 10'h025, 0, 1);
      add(0, 0, 0, 1, 1, 10'h000, 0, 10'h000, 1, 0);
      run_vecs("bp");
      chk("bp rd_ptr", 32'(rd_ptr_o), 32'h026);

      // Start while busy with a bad config is ignored
      set_cfg(10'h000, 11'h400, 10'h010, 11'd4);
      fill_basic(1'b1);
      run_vecs("busy_start");

      // Rejected configurations
      reject("rej size0", 10'h000, 11'd0, 10'h000, 11'd4);
      reject("rej end", 10'h3FC, 11'd8, 10'h3FC, 11'd4);
      reject("rej addr", 10'h100, 11'd8, 10'h0FF, 11'd4);

      // Zero length: done only, no SRAM access
      set_cfg(10'h000, 11'h400, 10'h010, 11'd0);
      start_i = 1'b1;
      @(negedge clk);
      chk("len0 c0 cen", 32'(sram_cen_o), 32'd1);
      tick();
      start_i = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk($sformatf("len0 c%0d done", c), 32'(done_o), 32'(c == 1));
         chk($sformatf("len0 c%0d cen", c), 32'(sram_cen_o), 32'd1);
         chk($sformatf("len0 c%0d busy", c), 32'(busy_o), 32'd0);
         chk($sformatf("len0 c%0d err", c), 32'(err_o), 32'd0);
         tick();
      end

      // Abort in cycle 5 of a long transfer
      set_cfg(10'h000, 11'h400, 10'h040, 11'd16);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int c = 1; c <= 4; c++) tick();
      abort_i = 1'b1;
      @(negedge clk);
      chk("abort c5 valid", 32'(valid_o), 32'd1);
      chk("abort c5 data", data_o, mem_f(10'h042));
      tick();
      abort_i = 1'b0;
      for (int c = 6; c <= 10; c++) begin
         @(negedge clk);
         chk($sformatf("abort c%0d valid", c), 32'(valid_o), 32'd0);
         chk($sformatf("abort c%0d busy", c), 32'(busy_o), 32'd0);
         chk($sformatf("abort c%0d done", c), 32'(done_o), 32'd0);
         chk($sformatf("abort c%0d cen", c), 32'(sram_cen_o), 32'd1);
         chk($sformatf("abort c%0d rd_ptr", c), 32'(rd_ptr_o), 32'h044);
         tick();
      end
      set_cfg(10'h000, 11'h400, 10'h010, 11'd4);
      fill_basic(1'b0);
      run_vecs("post_abort");

      // Start together with abort in IDLE: start wins
      set_cfg(10'h000, 11'h400, 10'h050, 11'd1);
      start_i = 1'b1;
      abort_i = 1'b1;
      tick();
      start_i = 1'b0;
      abort_i = 1'b0;
      @(negedge clk);
      chk("st_ab c1 busy", 32'(busy_o), 32'd1);
      chk("st_ab c1 cen", 32'(sram_cen_o), 32'd0);
      chk("st_ab c1 addr", 32'(sram_addr_o), 32'h050);
      tick();
      tick();
      @(negedge clk);
      chk("st_ab c3 data", data_o, mem_f(10'h050));
      tick();
      @(negedge clk);
      chk("st_ab c4 done", 32'(done_o), 32'd1);
      tick();

      // Reset in the middle of a transfer
      set_cfg(10'h000, 11'h400, 10'h080, 11'd8);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      tick();
      tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      for (int c = 4; c <= 5; c++) begin
         @(negedge clk);
         chk($sformatf("mrst c%0d busy", c), 32'(busy_o), 32'd0);
         chk($sformatf("mrst c%0d valid", c), 32'(valid_o), 32'd0);
         chk($sformatf("mrst c%0d data", c), data_o, 32'd0);
         chk($sformatf("mrst c%0d cen", c), 32'(sram_cen_o), 32'd1);
         chk($sformatf("mrst c%0d rd_ptr", c), 32'(rd_ptr_o), 32'd0);
         chk($sformatf("mrst c%0d done", c), 32'(done_o), 32'd0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
